// File: rtl/uart_loopback_extend_pkg.sv
// Shared constants and types for the UART echo block.
// Holds the default clock and baud figures and the frame bit-index markers.
// Also holds the idle/busy state encoding used by the RX and TX machines.
package uart_loopback_extend_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_UART_BPS = 9600;
  localparam int DEF_BPS_CNT  = DEF_CLK_FREQ / DEF_UART_BPS;

  // Bit positions inside a 10-bit 8N1 frame.
  localparam logic [3:0] START_IDX     = 4'd0;
  localparam logic [3:0] STOP_IDX      = 4'd9;
  localparam logic [3:0] LAST_DATA_IDX = 4'd8;

  typedef enum logic {
    LINE_IDLE = 1'b0,
    LINE_BUSY = 1'b1
  } line_state_t;

endpackage

// File: rtl/uart_loopback_extend_tx.sv
// 8N1 serialiser: frames one byte per start strobe, LSB first.
// Latency: the start bit appears on txd one clock after the start strobe.
// No backpressure; start is ignored while busy, so the caller must wait for busy=0.
module uart_tx
  import uart_loopback_extend_pkg::*;
#(
  parameter int BPS_CNT = DEF_BPS_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam int CNT_W = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  line_state_t      state;
  line_state_t      state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LINE_IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave idle on a strobe, return after the last stop-bit clock.
  always_comb begin
    state_nxt = state;
    case (state)
      LINE_IDLE: if (start) state_nxt = LINE_BUSY;
      LINE_BUSY: if (bit_end && (bit_idx == STOP_IDX)) state_nxt = LINE_IDLE;
      default:   state_nxt = LINE_IDLE;
    endcase
  end

  // Outputs derived from state.
  always_comb begin
    busy = (state == LINE_BUSY);
  end

  // Bit timing and a registered line driver so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= START_IDX;
      shreg   <= '0;
      txd     <= 1'b1;
    end else if (state == LINE_IDLE) begin
      clk_cnt <= '0;
      bit_idx <= START_IDX;
      if (start) begin
        shreg <= data;
        txd   <= 1'b0;
      end
    end else if (bit_end) begin
      clk_cnt <= '0;
      if (bit_idx == STOP_IDX) begin
        txd <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == LAST_DATA_IDX) begin
          txd <= 1'b1;
        end else begin
          txd   <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_loopback_extend.sv
// UART echo: receives 8N1 bytes on uart_rxd and retransmits them on uart_txd.
// Latency: uart_txd falls two clocks after the receiver accepts a stop bit.
// No backpressure; a byte arriving while one is still pending overwrites it.
module uart_loopback_extend
  import uart_loopback_extend_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);

  logic             rxd_s1;
  logic             rxd_s2;
  logic             rxd_d;
  line_state_t      rx_state;
  line_state_t      rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_idx;
  logic [7:0]       rx_data;
  logic             start_edge;
  logic             sample;
  logic             rx_done;
  logic [7:0]       hold_data;
  logic             pending;
  logic             tx_busy;
  logic             tx_start;

  assign start_edge = rxd_d & ~rxd_s2;
  assign sample     = (rx_state == LINE_BUSY) && (rx_cnt == CNT_MID);
  assign tx_start   = pending & ~tx_busy;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  // RX state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_state <= LINE_IDLE;
    else            rx_state <= rx_state_nxt;
  end

  // RX next state: a high start mid-sample is a glitch; stop mid-sample always ends the frame.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      LINE_IDLE: if (start_edge) rx_state_nxt = LINE_BUSY;
      LINE_BUSY: begin
        if (sample && (((rx_idx == START_IDX) && rxd_s2) || (rx_idx == STOP_IDX)))
          rx_state_nxt = LINE_IDLE;
      end
      default:   rx_state_nxt = LINE_IDLE;
    endcase
  end

  // RX outputs: byte is accepted only when the stop bit reads high.
  always_comb begin
    rx_done = sample && (rx_idx == STOP_IDX) && rxd_s2;
  end

  // RX bit timing and LSB-first shift of the data bits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_cnt  <= '0;
      rx_idx  <= START_IDX;
      rx_data <= '0;
    end else begin
      if (rx_state == LINE_IDLE) begin
        rx_cnt <= '0;
        rx_idx <= START_IDX;
      end else if (rx_cnt == CNT_LAST) begin
        rx_cnt <= '0;
        rx_idx <= rx_idx + 4'd1;
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (sample && (rx_idx != START_IDX) && (rx_idx != STOP_IDX))
        rx_data <= {rxd_s2, rx_data[7:1]};
    end
  end

  // Holding register: a new byte wins over the TX handoff so nothing is dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_data <= '0;
      pending   <= 1'b0;
    end else begin
      if (rx_done) begin
        hold_data <= rx_data;
        pending   <= 1'b1;
      end else if (tx_start) begin
        pending <= 1'b0;
      end
    end
  end

  uart_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_tx (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (tx_start),
    .data  (hold_data),
    .txd   (uart_txd),
    .busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_loopback_extend.sv
// Directed bench for the UART echo block, run at 16 clocks per bit.
// A line monitor decodes every frame seen on uart_txd into a queue.
// Each test task drives rxd frames and checks the decoded echoes inline.
module tb_uart_loopback_extend;

  localparam int BPS  = 16;
  localparam int HALF = BPS / 2;

  typedef struct {
    logic [7:0] data;
    logic       start_ok;
    logic       stop_ok;
    longint     fall_cyc;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   rxd = 1'b1;
  logic   txd;
  longint cyc = 0;
  longint rx_fall_cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  frame_t mon_q[$];
  frame_t mon_f;

  uart_loopback_extend #(
    .CLK_FREQ (800_000),
    .UART_BPS (50_000)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_rxd  (rxd),
    .uart_txd  (txd)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes frames at mid-bit on falling clock edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        mon_f.fall_cyc = cyc;
        repeat (HALF - 1) @(negedge clk);
        mon_f.start_ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(negedge clk);
          mon_f.data[i] = txd;
        end
        repeat (BPS) @(negedge clk);
        mon_f.stop_ok = (txd === 1'b1);
        mon_q.push_back(mon_f);
      end
    end
  end

  task automatic idle_bits(input int n);
    repeat (n * BPS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clk); #1;
    rx_fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (BPS) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic get_frame(output frame_t f, output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (mon_q.size() == 0 && n < 30 * BPS) begin
      @(negedge clk);
      n++;
    end
    if (mon_q.size() != 0) begin
      f = mon_q.pop_front();
      got = 1'b1;
    end else begin
      f.data = 8'hxx; f.start_ok = 1'b0; f.stop_ok = 1'b0; f.fall_cyc = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_txd: got %b expected 1", txd);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (txd !== 1'b1 || mon_q.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: txd %b frames %0d expected txd 1 frames 0", txd, mon_q.size());
    end
  endtask

  task automatic test_single_55();
    frame_t f;
    bit got;
    longint lat;
    send_frame(8'h55, 1'b1);
    get_frame(f, got);
    lat = f.fall_cyc - rx_fall_cyc;
    vectors++;
    if (!got || f.data !== 8'h55) begin
      miscompares++;
      $display("FAIL t55_data: got %h (seen %0d) expected 55", f.data, got);
    end
    vectors++;
    if (f.start_ok !== 1'b1 || f.stop_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL t55_framing: start_ok %b stop_ok %b expected 1 1", f.start_ok, f.stop_ok);
    end
    vectors++;
    if (lat < 9 * BPS + HALF + 2 || lat > 9 * BPS + HALF + 6) begin
      miscompares++;
      $display("FAIL t55_latency: got %0d cycles expected %0d..%0d", lat, 9 * BPS + HALF + 2, 9 * BPS + HALF + 6);
    end
    idle_bits(3);
    #1;
    vectors++;
    if (txd !== 1'b1 || mon_q.size() != 0) begin
      miscompares++;
      $display("FAIL t55_idle_after: txd %b frames %0d expected 1 0", txd, mon_q.size());
    end
  endtask

  task automatic test_00_ff();
    frame_t f;
    bit got;
    logic [7:0] exp_d [2];
    exp_d[0] = 8'h00;
    exp_d[1] = 8'hFF;
    send_frame(8'h00, 1'b1);
    idle_bits(1);
    send_frame(8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      get_frame(f, got);
      vectors++;
      if (!got || f.data !== exp_d[k] || f.start_ok !== 1'b1 || f.stop_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL t00ff_frame%0d: data %h start %b stop %b seen %0d expected %h 1 1", k, f.data, f.start_ok, f.stop_ok, got, exp_d[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    bit got;
    longint first_fall;
    logic [7:0] exp_d [2];
    exp_d[0] = 8'hA5;
    exp_d[1] = 8'h3C;
    idle_bits(2);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    first_fall = 0;
    for (int k = 0; k < 2; k++) begin
      get_frame(f, got);
      vectors++;
      if (!got || f.data !== exp_d[k] || f.start_ok !== 1'b1 || f.stop_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: data %h start %b stop %b seen %0d expected %h 1 1", k, f.data, f.start_ok, f.stop_ok, got, exp_d[k]);
      end
      if (k == 0) first_fall = f.fall_cyc;
    end
    vectors++;
    if (f.fall_cyc - first_fall < 10 * BPS || f.fall_cyc - first_fall > 10 * BPS + 3) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d cycles expected %0d..%0d", f.fall_cyc - first_fall, 10 * BPS, 10 * BPS + 3);
    end
  endtask

  task automatic test_glitch();
    int low_seen;
    idle_bits(2);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    #1;
    rxd = 1'b1;
    low_seen = 0;
    repeat (25 * BPS) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    vectors++;
    if (low_seen != 0) begin
      miscompares++;
      $display("FAIL glitch_txd: txd left 1 for %0d cycles expected 0", low_seen);
    end
    vectors++;
    if (mon_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_frames: got %0d frames expected 0", mon_q.size());
    end
  endtask

  task automatic test_framing_error();
    frame_t f;
    bit got;
    send_frame(8'h12, 1'b0);
    idle_bits(2);
    send_frame(8'h34, 1'b1);
    get_frame(f, got);
    vectors++;
    if (!got || f.data !== 8'h34 || f.start_ok !== 1'b1 || f.stop_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_next_frame: data %h start %b stop %b seen %0d expected 34 1 1", f.data, f.start_ok, f.stop_ok, got);
    end
    idle_bits(3);
    vectors++;
    if (mon_q.size() != 0) begin
      miscompares++;
      $display("FAIL ferr_extra_frames: got %0d expected 0", mon_q.size());
    end
  endtask

  task automatic test_reset_mid_echo();
    int low_seen;
    send_frame(8'h55, 1'b1);
    repeat (3 * BPS) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_txd: got %b expected 1", txd);
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(12);
    mon_q.delete();
    low_seen = 0;
    repeat (25 * BPS) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    vectors++;
    if (low_seen != 0) begin
      miscompares++;
      $display("FAIL rst_mid_stale_txd: txd left 1 for %0d cycles expected 0", low_seen);
    end
    vectors++;
    if (mon_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_stale_frames: got %0d expected 0", mon_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_00_ff();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_echo();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
